// File: rtl/ctrl_encode_def.sv
// Shared control encodings: ALU ops, memory access size codes, memory-stage FSM states.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package ctrl_encode_def;

    // ALU operation select (datapath control)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;

    // Memory access size, op[1:0]; op[2] selects zero-extension on loads
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    // Memory access unit FSM state codes
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    // An access is rejected when it is not naturally aligned or uses the reserved size.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load alignment: picks the addressed byte/half from a RAM word and sign- or zero-extends it.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: i_word RAM read word, i_lane addr[1:0], i_op access op, o_data extended result.
module load_align
    import ctrl_encode_def::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian: byte lane n is bits [8n+7:8n]; addr[1] picks the upper half.
    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_op[1:0])
            SZ_B:    o_data = i_op[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_data = i_op[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: steers byte lanes to a word RAM, extends loads, flags misalignment.
// Latency: req to done = 2 cycles minimum (IDLE->ACCESS->RESP), +1 per RAM wait cycle.
// Backpressure: busy stalls the core while the request is held and the RAM has not returned mem_ready.
// Optional feature macro: MEM_TIMEOUT_EN (aborts an ACCESS after TIMEOUT cycles without mem_ready).
// Ports: clk/rst (sync, active-high); core side req/we/op/addr/wdata -> busy/done/rdata/misalign/timeout;
//        RAM side mem_req/mem_we/mem_be/mem_addr/mem_wdata -> mem_rdata/mem_ready.
module mem_access_unit
    import ctrl_encode_def::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_op;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_misalign;

    logic        w_access;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    assign w_access = (r_state == ST_ACCESS);

    // Store lane steering: narrow stores replicate the data so any lane picks it up.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        if (r_we) begin
            case (r_op[1:0])
                SZ_B: begin
                    w_be    = 4'b0001 << r_addr[1:0];
                    w_wdata = {4{r_wdata[7:0]}};
                end
                SZ_H: begin
                    w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{r_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = r_wdata;
                end
            endcase
        end
    end

    load_align u_load_align (
        .i_word (mem_rdata),
        .i_lane (r_addr[1:0]),
        .i_op   (r_op),
        .o_data (w_load)
    );

    // RAM-side outputs come from captured registers, so they are stable for the whole ACCESS.
    assign mem_req   = w_access;
    assign mem_we    = w_access & r_we;
    assign mem_be    = w_access ? w_be : 4'b0000;
    assign mem_addr  = w_access ? r_addr[31:2] : 30'b0;
    assign mem_wdata = w_access ? w_wdata : 32'b0;

    // busy is combinational on req so the core stalls in the same cycle it asks.
    assign busy     = ((r_state == ST_IDLE) & req) | w_access;
    assign done     = (r_state == ST_RESP);
    assign rdata    = r_rdata;
    assign misalign = r_misalign;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    assign timeout = r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign timeout          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= 32'b0;
            r_op       <= 3'b0;
            r_we       <= 1'b0;
            r_wdata    <= 32'b0;
            r_rdata    <= 32'b0;
            r_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_addr  <= addr;
                        r_op    <= op;
                        r_we    <= we;
                        r_wdata <= wdata;
                        // Misaligned accesses skip the RAM entirely and answer directly.
                        if (is_misaligned(op[1:0], addr[1:0])) begin
                            r_misalign <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            r_state <= ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    // mem_ready wins over the timeout in the final counted cycle.
                    if (mem_ready) begin
                        r_rdata <= r_we ? 32'b0 : w_load;
                        r_state <= ST_RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_rdata   <= 32'b0;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    r_rdata    <= 32'b0;
                    r_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    r_timeout  <= 1'b0;
`endif
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory access stage directly downstream of the datapath's ALU/store-data outputs: takes the effective address, store data and access type for lb/lbu/lh/lhu/lw/sb/sh/sw.
Drives a word-organised, variable-latency data RAM through a req/ready handshake, with byte-lane steering and load sign/zero extension.
Stalls the core while an access is in flight. Flags misaligned accesses instead of issuing them.

Parameters:
TIMEOUT, 16, ACCESS-state cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  1  core requests a memory access this instruction
we  in  1  1 = store, 0 = load
op  in  3  op[1:0] size (00 byte, 01 half, 10 word, 11 reserved); op[2] unsigned load
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rt value)
busy  out  1  stall to PC/register file
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result, valid while done=1
misalign  out  1  error flag, valid while done=1
timeout  out  1  abort flag, valid while done=1
mem_req  out  1  RAM request
mem_we  out  1  RAM write
mem_be  out  4  RAM byte enables, bit i = byte lane i
mem_addr  out  30  word address (addr[31:2])
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  RAM read word
mem_ready  in  1  RAM completes request this cycle

Behaviour:
- Reset: state IDLE; all outputs 0; internal captured registers 0.
- Three-state FSM: IDLE, ACCESS, RESP.
- busy = (IDLE & req) | ACCESS. busy is combinational. busy=0 in RESP, so the core retires in the RESP cycle.
- IDLE, req=1: capture addr, op, we and wdata.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, or size 11): go to RESP with misalign=1. mem_req is never asserted.
  - Otherwise: go to ACCESS.
- ACCESS: mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata held stable.
  - mem_ready=1 ends ACCESS; this includes mem_ready on the first ACCESS cycle (zero-wait RAM).
  - On mem_ready, the load result is registered and the FSM goes to RESP.
  - Minimum latency: req to done = 2 cycles.
- RESP: done=1 for exactly one cycle, then IDLE. Error flags and rdata clear when leaving RESP.
- req is ignored outside IDLE. mem_ready is ignored outside ACCESS.
- Byte enables: loads 1111. sb: 1<<addr[1:0]. sh: 0011 if addr[1]=0, else 1100. sw: 1111.
- Store data: sb replicates wdata[7:0] into all lanes; sh replicates wdata[15:0] into both halves.
- Loads, little-endian:
  - Byte lane = addr[1:0]; half = addr[1].
  - op[2]=0 sign-extends; op[2]=1 zero-extends. lw passes the word unchanged.
  - Stores return rdata=0.
- Reset asserted mid-ACCESS: mem_req=0 from the next edge; no done is produced.

Optional Feature:
Macro MEM_TIMEOUT_EN.
- Defined: a counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready. At count TIMEOUT-1 with no mem_ready, go to RESP with timeout=1, rdata=0, and drop mem_req. mem_ready in that same cycle takes priority (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; timeout tied 0.

Decomposition:
- Op/size encodings (SZ_B, SZ_H, SZ_W) and FSM state codes go in the shared ctrl_encode_def constants, alongside existing control encodings.
- Sub-module load_align (combinational): word + addr[1:0] + op → extended rdata. The store-lane steering stays inline.

Test Plan:
- lw addr 0x10, RAM ready on first ACCESS cycle, mem_rdata 0xDEADBEEF → mem_addr 0x4, be 1111, done in cycle 2, rdata 0xDEADBEEF, busy high for 2 cycles.
- lb/lbu addr 0x13 with mem_rdata 0x80123456 → rdata 0xFFFFFF80 / 0x00000080; lh/lhu addr 0x12 → 0xFFFF8012 / 0x00008012.
- sb addr 0x21 wdata 0x000000AB → be 0010, mem_wdata 0xABABABAB, mem_we=1, done with rdata 0.
- sh addr 0x21 → no mem_req, done next cycle with misalign=1; repeat with size 11 → same.
- lw with mem_ready delayed 5 cycles → mem_req and mem_addr stable throughout, done 1 cycle after ready; rst asserted in ACCESS cycle 3 → mem_req 0 next cycle, no done.
- With MEM_TIMEOUT_EN and TIMEOUT=16, mem_ready never asserted → timeout=1 with done after 16 ACCESS cycles; ready on cycle 16 → normal completion, timeout=0.
